// File: rtl/aes_ahb_pkg.sv
// aes_ahb_pkg
//   Shared types and constants for the AES AHB-Lite initiator.
//   - op_t     : command opcodes (3 is illegal and is rejected without bus activity)
//   - state_t  : initiator state machine encoding
//   - HTRANS_* / HSIZE_128 / HBURST_SINGLE : AHB-Lite encodings used by this initiator
//   - op_addr  : combinational address decode (base + per-opcode offset)
//   - op_is_write : opcode -> HWRITE
//   Build option: AES_AHB_RETRY_EN (used by aes_ahb_master, not by this package).
package aes_ahb_pkg;

  typedef enum logic [1:0] {
    OP_WKEY    = 2'd0,
    OP_WDATA   = 2'd1,
    OP_RDATA   = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_128     = 3'b100;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Address for an opcode. The illegal opcode never reaches the bus, so its
  // value is irrelevant; it decodes to the base address.
  function automatic logic [31:0] op_addr(
    input op_t         op,
    input logic [31:0] base,
    input logic [31:0] key_ofs,
    input logic [31:0] wdata_ofs,
    input logic [31:0] rdata_ofs
  );
    logic [31:0] addr;
    case (op)
      OP_WKEY:  addr = base + key_ofs;
      OP_WDATA: addr = base + wdata_ofs;
      OP_RDATA: addr = base + rdata_ofs;
      default:  addr = base;
    endcase
    return addr;
  endfunction

  function automatic logic op_is_write(input op_t op);
    return (op == OP_WKEY) || (op == OP_WDATA);
  endfunction

endpackage

// File: rtl/aes_ahb_master.sv
// aes_ahb_master
//   AHB-Lite initiator for the 128-bit AES slave. Accepts one command at a
//   time (write key, write data, read data) and issues it as a single NONSEQ
//   transfer, then reports completion with a one-cycle rsp_valid pulse.
//   All outputs are registered.
//
//   Ports
//     clk, n_rst                 clock (rising edge), asynchronous active-low reset
//     cmd_valid/cmd_ready        command handshake (ready only while idle)
//     cmd_op, cmd_wdata          opcode and write payload, sampled at accept
//     rsp_valid/rsp_error        completion pulse and its error qualifier
//     rsp_data                   HRDATA of the last OKAY read, held between reads
//     HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA   AHB-Lite initiator outputs
//     HRDATA/HREADY/HRESP        AHB-Lite slave response inputs
//
//   Build option
//     AES_AHB_RETRY_EN : when defined, an ERROR response reissues the same
//                        transfer up to MAX_RETRIES times before reporting
//                        rsp_error. When undefined, every ERROR completes at once.
module aes_ahb_master
  import aes_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] KEY_OFS     = 32'h00,
  parameter logic [31:0] WDATA_OFS   = 32'h10,
  parameter logic [31:0] RDATA_OFS   = 32'h20,
  parameter int          MAX_RETRIES = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  op_t          cmd_op,
  input  logic [127:0] cmd_wdata,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_error,
  output logic [31:0]  HADDR,
  output logic [1:0]   HTRANS,
  output logic         HWRITE,
  output logic [2:0]   HSIZE,
  output logic [2:0]   HBURST,
  output logic [127:0] HWDATA,
  input  logic [127:0] HRDATA,
  input  logic         HREADY,
  input  logic         HRESP
);

  state_t       state_q, state_d;
  op_t          op_q, op_d;
  logic [127:0] wdata_q, wdata_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_error_q, rsp_error_d;
  logic [127:0] rsp_data_q, rsp_data_d;
  logic [31:0]  haddr_q, haddr_d;
  logic [1:0]   htrans_q, htrans_d;
  logic         hwrite_q, hwrite_d;
  logic [127:0] hwdata_q, hwdata_d;
  logic         err_done;

`ifdef AES_AHB_RETRY_EN
  logic [1:0]   retry_q, retry_d;
`else
  localparam int max_retries_unused = MAX_RETRIES;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WKEY;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
`ifdef AES_AHB_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
`ifdef AES_AHB_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    err_done    = 1'b0;
`ifdef AES_AHB_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          wdata_d = cmd_wdata;
`ifdef AES_AHB_RETRY_EN
          retry_d = '0;
`endif
          if (cmd_op == OP_ILLEGAL) begin
            // Rejected locally: answer next cycle, bus untouched.
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = op_addr(cmd_op, BASE_ADDR, KEY_OFS, WDATA_OFS, RDATA_OFS);
            hwrite_d = op_is_write(cmd_op);
          end
        end
      end

      ST_ADDR: begin
        // Address/control stay registered and unchanged while HREADY is low.
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      ST_DATA: begin
        if (HRESP) begin
          // HREADY high on the first ERROR cycle breaks the two-cycle rule;
          // it is still taken as an ERROR completion.
          if (HREADY) begin
            err_done = 1'b1;
          end else begin
            state_d = ST_ERR2;
          end
        end else if (HREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          if (op_q == OP_RDATA) begin
            rsp_data_d = HRDATA;
          end
        end
      end

      ST_ERR2: begin
        if (HREADY) begin
          err_done = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (err_done) begin
`ifdef AES_AHB_RETRY_EN
      if (int'(retry_q) < MAX_RETRIES) begin
        // Reissue the identical transfer; HADDR/HWRITE still hold it.
        retry_d  = retry_q + 2'd1;
        state_d  = ST_ADDR;
        htrans_d = HTRANS_NONSEQ;
      end else begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
      end
`else
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b1;
      rsp_error_d = 1'b1;
`endif
    end

    // Ready is withheld in the response cycle so a response and the next
    // accept never share a cycle.
    cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_data  = rsp_data_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_128;
  assign HBURST    = HBURST_SINGLE;

endmodule

// File: tb/tb_aes_ahb_master.sv
// tb_aes_ahb_master
//   Self-checking bench for aes_ahb_master. A scripted AHB slave (per command:
//   address wait states, data wait states, number of leading transfers that
//   answer ERROR) responds to the DUT; expected response cycle, error flag and
//   transfer count come from a directed table and, for random commands, from
//   a closed-form model of the transfer timing.
//   Honours AES_AHB_RETRY_EN the same way as the design.
module tb_aes_ahb_master;
  import aes_ahb_pkg::*;

  localparam int MAXR = 2;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  op_t          cmd_op = OP_WKEY;
  logic [127:0] cmd_wdata = '0;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_error;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [127:0] HWDATA;
  logic [127:0] HRDATA = '0;
  logic         HREADY = 1'b1;
  logic         HRESP = 1'b0;

  always #5 clk = ~clk;

  aes_ahb_master #(.MAX_RETRIES(MAXR)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]   op;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           aw;       // address-phase wait states
    int           dw;       // data-phase wait states before the answer
    int           err_n;    // number of leading transfers answered with ERROR
    bit           hold;     // keep cmd_valid asserted while busy
    int           exp_cyc;  // cycle of rsp_valid, accept = cycle 0
    bit           exp_err;
    int           exp_nx;   // transfers seen on the bus
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [1:0] op);
    case (op)
      2'd0:    return 32'h00;
      2'd1:    return 32'h10;
      default: return 32'h20;
    endcase
  endfunction

  // Every transfer costs one address cycle plus its waits, one data cycle
  // plus its waits, and one more cycle if it is answered with a two-cycle ERROR.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int   max_x;
    r = v;
`ifdef AES_AHB_RETRY_EN
    max_x = MAXR + 1;
`else
    max_x = 1;
`endif
    if (v.op == 2'd3) begin
      r.exp_cyc = 1;
      r.exp_err = 1'b1;
      r.exp_nx  = 0;
    end else begin
      r.exp_nx  = (v.err_n < max_x) ? v.err_n + 1 : max_x;
      r.exp_err = (v.err_n >= r.exp_nx);
      r.exp_cyc = 1 + r.exp_nx * (2 + v.aw + v.dw) + ((v.err_n < r.exp_nx) ? v.err_n : r.exp_nx);
    end
    return r;
  endfunction

  task automatic run_cmd(input vec_t v, input string tag);
    int           cyc;
    int           acnt;
    int           dcnt;
    int           nx;
    int           got_cyc;
    bit           in_data;
    bit           cur_err;
    bit           done;
    bit           bus_ok;
    bit           got_err;
    bit           hr;
    bit           hp;
    logic [127:0] hrd;
    logic [127:0] got_data;
    bit           is_wr;

    is_wr = (v.op == 2'd0) || (v.op == 2'd1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op_t'(v.op);
    cmd_wdata = v.wdata;
    @(posedge clk); #1;
    if (v.hold) begin
      cmd_op    = OP_WKEY;
      cmd_wdata = ~v.wdata;
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 1; acnt = 0; dcnt = 0; nx = 0; in_data = 0; cur_err = 0;
    done = 0; bus_ok = 1; got_cyc = -1; got_err = 0; got_data = '0;
    while (!done && cyc < 300) begin
      hr  = 1'b1;
      hp  = 1'b0;
      hrd = {$urandom, $urandom, $urandom, $urandom};
      if (rsp_valid) begin
        done     = 1;
        got_cyc  = cyc;
        got_err  = rsp_error;
        got_data = rsp_data;
        if (cmd_ready) bus_ok = 0;
        cmd_valid = 1'b0;
      end else begin
        if (cmd_ready) bus_ok = 0;
        if (in_data) begin
          if (HTRANS !== HTRANS_IDLE) bus_ok = 0;
          if (is_wr && HWDATA !== v.wdata) bus_ok = 0;
          if (dcnt < v.dw) begin
            hr = 1'b0;
          end else if (cur_err && dcnt == v.dw) begin
            hr = 1'b0; hp = 1'b1;
          end else if (cur_err) begin
            hr = 1'b1; hp = 1'b1;
          end else begin
            hrd = v.rdata;
          end
          if (hr) in_data = 0;
          else dcnt++;
        end else if (HTRANS === HTRANS_NONSEQ) begin
          if (HADDR !== exp_addr(v.op) || HWRITE !== is_wr) bus_ok = 0;
          hr = (acnt >= v.aw);
          if (hr) begin
            in_data = 1; cur_err = (nx < v.err_n); nx++; dcnt = 0; acnt = 0;
          end else begin
            acnt++;
          end
        end else if (HTRANS !== HTRANS_IDLE) begin
          bus_ok = 0;
        end
      end
      HREADY = hr;
      HRESP  = hp;
      HRDATA = hrd;
      @(posedge clk); #1;
      cyc++;
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    check({tag, " rsp_cycle"}, 128'(got_cyc), 128'(v.exp_cyc));
    check({tag, " rsp_error"}, 128'(got_err), 128'(v.exp_err));
    check({tag, " transfers"}, 128'(nx), 128'(v.exp_nx));
    check({tag, " bus_protocol"}, 128'(bus_ok), 128'(1));
    if (v.op == 2'd2 && !v.exp_err) check({tag, " rsp_data"}, got_data, v.rdata);
    if (done) begin
      check({tag, " rsp_pulse"}, 128'(rsp_valid), 128'(0));
      check({tag, " ready_after"}, 128'(cmd_ready), 128'(1));
    end
  endtask

  vec_t dir_tab[7];

  initial begin
    vec_t v;
    bit   quiet;
    int   r;

    // Directed table: op, wdata, rdata, aw, dw, err_n, hold, exp_cyc, exp_err, exp_nx
    dir_tab[0] = '{2'd0, 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 0, 0, 0, 1'b0, 3, 1'b0, 1};
    dir_tab[1] = '{2'd2, 128'h0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 0, 3, 0, 1'b0, 6, 1'b0, 1};
    dir_tab[2] = '{2'd1, 128'h11112222333344445555666677778888, 128'h0, 2, 0, 0, 1'b0, 5, 1'b0, 1};
`ifdef AES_AHB_RETRY_EN
    dir_tab[3] = '{2'd1, 128'hcafef00dcafef00dcafef00dcafef00d, 128'h0, 0, 0, 99, 1'b0, 10, 1'b1, 3};
    dir_tab[6] = '{2'd1, 128'h0f0e0d0c0b0a09080706050403020100, 128'h0, 0, 0, 1, 1'b0, 6, 1'b0, 2};
`else
    dir_tab[3] = '{2'd1, 128'hcafef00dcafef00dcafef00dcafef00d, 128'h0, 0, 0, 99, 1'b0, 4, 1'b1, 1};
    dir_tab[6] = '{2'd1, 128'h0f0e0d0c0b0a09080706050403020100, 128'h0, 0, 0, 1, 1'b0, 4, 1'b1, 1};
`endif
    dir_tab[4] = '{2'd3, 128'h5a5a, 128'h0, 0, 0, 0, 1'b0, 1, 1'b1, 0};
    dir_tab[5] = '{2'd2, 128'h0, 128'h0123456789abcdeffedcba9876543210, 1, 1, 0, 1'b1, 5, 1'b0, 1};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("reset cmd_ready", 128'(cmd_ready), 128'(1));
    check("reset rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset rsp_error", 128'(rsp_error), 128'(0));
    check("reset rsp_data", rsp_data, 128'h0);
    check("reset HADDR", 128'(HADDR), 128'h0);
    check("reset HTRANS", 128'(HTRANS), 128'(HTRANS_IDLE));
    check("reset HWRITE", 128'(HWRITE), 128'(0));
    check("reset HWDATA", HWDATA, 128'h0);
    check("HSIZE", 128'(HSIZE), 128'(3'b100));
    check("HBURST", 128'(HBURST), 128'(3'b000));
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_cmd(dir_tab[i], $sformatf("dir%0d", i));
      $display("dir%0d op=%0d aw=%0d dw=%0d err_n=%0d exp_cyc=%0d exp_err=%0d",
               i, dir_tab[i].op, dir_tab[i].aw, dir_tab[i].dw, dir_tab[i].err_n,
               dir_tab[i].exp_cyc, dir_tab[i].exp_err);
    end

    for (int i = 0; i < 40; i++) begin
      r       = $urandom_range(0, 15);
      v.op    = (r == 15) ? 2'd3 : 2'(r % 3);
      v.wdata = {$urandom, $urandom, $urandom, $urandom};
      v.rdata = {$urandom, $urandom, $urandom, $urandom};
      v.aw    = $urandom_range(0, 2);
      v.dw    = $urandom_range(0, 3);
      v.err_n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      v.hold  = ($urandom_range(0, 3) == 0);
      v = predict(v);
      run_cmd(v, $sformatf("rnd%0d", i));
      $display("rnd%0d op=%0d aw=%0d dw=%0d err_n=%0d exp_cyc=%0d exp_err=%0d",
               i, v.op, v.aw, v.dw, v.err_n, v.exp_cyc, v.exp_err);
    end

    // A known nonzero read result so the reset check below is meaningful.
    v = '{2'd2, 128'h0, 128'hfeedfacefeedfacefeedfacefeedface, 0, 0, 0, 1'b0, 3, 1'b0, 1};
    run_cmd(v, "pre_abort_read");
    v = '{2'd0, 128'habcdabcdabcdabcdabcdabcdabcdabcd, 128'h0, 0, 0, 0, 1'b0, 3, 1'b0, 1};
    run_cmd(v, "pre_abort_write");

    // Reset asserted asynchronously while a read waits in its data phase.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_RDATA;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    @(posedge clk); #1;          // cycle 1: address phase, accepted
    cmd_valid = 1'b0;
    @(posedge clk); #1;          // cycle 2: data phase
    HREADY = 1'b0;
    @(posedge clk); #1;          // cycle 3: still waiting
    check("abort in_data HTRANS", 128'(HTRANS), 128'(HTRANS_IDLE));
    #2;
    n_rst = 1'b0;
    #1;
    check("abort cmd_ready", 128'(cmd_ready), 128'(1));
    check("abort rsp_valid", 128'(rsp_valid), 128'(0));
    check("abort rsp_data", rsp_data, 128'h0);
    check("abort HADDR", 128'(HADDR), 128'h0);
    check("abort HTRANS", 128'(HTRANS), 128'(HTRANS_IDLE));
    check("abort HWDATA", HWDATA, 128'h0);
    @(negedge clk);
    n_rst  = 1'b1;
    HREADY = 1'b1;
    quiet  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || HTRANS !== HTRANS_IDLE) quiet = 1'b0;
    end
    check("abort no_response", 128'(quiet), 128'(1));
    $display("abort sequence done quiet=%0d", quiet);

    v = '{2'd1, 128'h77777777888888889999999900000000, 128'h0, 1, 2, 0, 1'b0, 6, 1'b0, 1};
    run_cmd(v, "post_abort");
    $display("post_abort op=1 exp_cyc=6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
